// File: rtl/pc_fetch_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_stage_if : redirect, instruction-memory and IF/ID bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_fetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_pc_plus4, if_instr
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_fetch_stage : PC, imem req/ack fetch, IF/ID register, hold buffer, redirects
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pc_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] c_reset_pc = RESET_PC & ~32'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] hpc_q, hpc_d;
  logic [31:0] hinstr_q, hinstr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic [31:0] pc_plus4;
  logic [31:0] hpc_plus4;
  logic [31:0] target;
  logic        slot_free;

  assign pc_plus4  = pc_q + 32'd4;
  assign hpc_plus4 = hpc_q + 32'd4;
  assign target    = bus.redirect_target & ~32'd3;
  assign slot_free = !if_valid_q || !bus.stall;

  assign bus.imem_req    = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;
  assign bus.if_instr    = if_instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= c_reset_pc;
      pend_pc_q     <= 32'd0;
      hpc_q         <= 32'd0;
      hinstr_q      <= 32'd0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      if_instr_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      hpc_q         <= hpc_d;
      hinstr_q      <= hinstr_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    hpc_d         = hpc_q;
    hinstr_d      = hinstr_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;

    // Decode consumes the current entry; a load below may refill it.
    if (if_valid_q && !bus.stall) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          if_valid_d = 1'b0;
          if (bus.imem_ack) begin
            pc_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = DRAIN;
          end
        end else if (bus.imem_ack) begin
          pc_d = pc_plus4;
          if (slot_free) begin
            if_valid_d    = 1'b1;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            if_instr_d    = bus.imem_rdata;
          end else begin
            hpc_d    = pc_q;
            hinstr_d = bus.imem_rdata;
            state_d  = HOLD;
          end
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          if_valid_d = 1'b0;
          hpc_d      = 32'd0;
          hinstr_d   = 32'd0;
          pc_d       = target;
          state_d    = FETCH;
        end else if (!bus.stall) begin
          if_valid_d    = 1'b1;
          if_pc_d       = hpc_q;
          if_pc_plus4_d = hpc_plus4;
          if_instr_d    = hinstr_q;
          state_d       = FETCH;
        end
      end

      DRAIN: begin
        // The stale request must complete before the target can be issued.
        if (bus.redirect_valid) begin
          if_valid_d = 1'b0;
          pend_pc_d  = target;
          if (bus.imem_ack) begin
            pc_d    = target;
            state_d = FETCH;
          end
        end else if (bus.imem_ack) begin
          pc_d    = pend_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_fetch_stage : directed vector table plus random run against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_fetch_stage;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_fetch_stage_if bus ();
  pc_fetch_stage_if bus2 ();

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // Wrap-around instance: zero-wait memory, never stalled or redirected.
  assign bus2.stall           = 1'b0;
  assign bus2.redirect_valid  = 1'b0;
  assign bus2.redirect_target = 32'd0;
  assign bus2.imem_ack        = bus2.imem_req;
  assign bus2.imem_rdata      = bus2.imem_addr ^ PAT;

  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          r;
    bit          s;
    bit          d;
    logic [31:0] t;
    bit          a;
    bit          er;
    logic [31:0] ea;
    bit          ev;
    logic [31:0] ep;
  } vec_t;

  function automatic vec_t v(bit r, bit s, bit d, logic [31:0] t, bit a,
                             bit er, logic [31:0] ea, bit ev, logic [31:0] ep);
    vec_t x;
    x.r = r; x.s = s; x.d = d; x.t = t; x.a = a;
    x.er = er; x.ea = ea; x.ev = ev; x.ep = ep;
    return x;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  task automatic drive(input bit r, input bit s, input bit d, input logic [31:0] t,
                       input bit a, input logic [31:0] rd);
    reset               = r;
    bus.stall           = s;
    bus.redirect_valid  = d;
    bus.redirect_target = t;
    bus.imem_ack        = a;
    bus.imem_rdata      = rd;
  endtask

  vec_t vecs [32];
  logic [31:0] wrap_pc [4];

  initial begin
    ent_t        q [$];
    logic [31:0] mpc;
    logic [31:0] pend;
    bit          drain;
    bit          r, s, d, a, er;
    logic [31:0] t, rd;

    // in: rst stall redir target ack | exp: req addr valid pc
    vecs[0]  = v(0,0,0,32'h0,  1, 1,32'h0,  0,32'h0);
    vecs[1]  = v(0,0,0,32'h0,  1, 1,32'h4,  1,32'h0);
    vecs[2]  = v(0,0,0,32'h0,  1, 1,32'h8,  1,32'h4);
    vecs[3]  = v(0,1,0,32'h0,  1, 1,32'hc,  1,32'h8);
    vecs[4]  = v(0,1,0,32'h0,  0, 0,32'h10, 1,32'h8);
    vecs[5]  = v(0,1,0,32'h0,  0, 0,32'h10, 1,32'h8);
    vecs[6]  = v(0,0,0,32'h0,  0, 0,32'h10, 1,32'h8);
    vecs[7]  = v(0,0,0,32'h0,  1, 1,32'h10, 1,32'hc);
    vecs[8]  = v(0,0,0,32'h0,  1, 1,32'h14, 1,32'h10);
    vecs[9]  = v(0,1,1,32'h43, 1, 1,32'h18, 1,32'h14);
    vecs[10] = v(0,0,0,32'h0,  1, 1,32'h40, 0,32'h0);
    vecs[11] = v(0,0,0,32'h0,  0, 1,32'h44, 1,32'h40);
    vecs[12] = v(1,0,0,32'h0,  0, 0,32'h44, 0,32'h0);
    vecs[13] = v(1,0,0,32'h0,  0, 0,32'h0,  0,32'h0);
    vecs[14] = v(0,0,0,32'h0,  1, 1,32'h0,  0,32'h0);
    vecs[15] = v(0,0,0,32'h0,  1, 1,32'h4,  1,32'h0);
    vecs[16] = v(0,0,0,32'h0,  1, 1,32'h8,  1,32'h4);
    vecs[17] = v(0,0,0,32'h0,  1, 1,32'hc,  1,32'h8);
    vecs[18] = v(0,0,1,32'h103,0, 1,32'h10, 1,32'hc);
    vecs[19] = v(0,0,0,32'h0,  0, 1,32'h10, 0,32'h0);
    vecs[20] = v(0,0,0,32'h0,  1, 1,32'h10, 0,32'h0);
    vecs[21] = v(0,0,0,32'h0,  1, 1,32'h100,0,32'h0);
    vecs[22] = v(0,0,1,32'h303,0, 1,32'h104,1,32'h100);
    vecs[23] = v(1,0,0,32'h0,  0, 0,32'h104,0,32'h0);
    vecs[24] = v(0,0,0,32'h0,  1, 1,32'h0,  0,32'h0);
    vecs[25] = v(0,1,0,32'h0,  1, 1,32'h4,  1,32'h0);
    vecs[26] = v(1,1,0,32'h0,  0, 0,32'h8,  1,32'h0);
    vecs[27] = v(0,0,0,32'h0,  0, 1,32'h0,  0,32'h0);
    vecs[28] = v(0,0,0,32'h0,  1, 1,32'h0,  0,32'h0);
    vecs[29] = v(0,0,0,32'h0,  0, 1,32'h4,  1,32'h0);
    vecs[30] = v(0,0,0,32'h0,  1, 1,32'h4,  0,32'h0);
    vecs[31] = v(0,0,0,32'h0,  0, 1,32'h8,  1,32'h4);

    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFF8;
    wrap_pc[2] = 32'hFFFF_FFFC;
    wrap_pc[3] = 32'h0000_0000;

    // Reset values
    drive(1, 0, 0, 32'd0, 0, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check32("rst_req",    {31'd0, bus.imem_req}, 32'd0);
    check32("rst_valid",  {31'd0, bus.if_valid}, 32'd0);
    check32("rst_pc",     bus.if_pc,             32'd0);
    check32("rst_plus4",  bus.if_pc_plus4,       32'd0);
    check32("rst_instr",  bus.if_instr,          32'd0);
    check32("rst_addr",   bus.imem_addr,         32'd0);
    check32("rst_req2",   {31'd0, bus2.imem_req}, 32'd0);

    // Wrap-around sequence from RESET_PC = FFFF_FFF8
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k == 0) begin
        check32("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFF8);
        check32("wrap_first_valid", {31'd0, bus2.if_valid}, 32'd0);
        check32("first_req", {31'd0, bus.imem_req}, 32'd1);
      end else begin
        check32("wrap_valid", {31'd0, bus2.if_valid}, 32'd1);
        check32("wrap_pc",    bus2.if_pc,       wrap_pc[k]);
        check32("wrap_plus4", bus2.if_pc_plus4, wrap_pc[k] + 32'd4);
        check32("wrap_instr", bus2.if_instr,    wrap_pc[k] ^ PAT);
      end
      @(negedge clk);
    end

    // Directed vector table
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].t, vecs[i].a, bus.imem_addr ^ PAT);
      #1;
      check32($sformatf("vec%0d_req", i),   {31'd0, bus.imem_req}, {31'd0, vecs[i].er});
      check32($sformatf("vec%0d_addr", i),  bus.imem_addr,         vecs[i].ea);
      check32($sformatf("vec%0d_valid", i), {31'd0, bus.if_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        check32($sformatf("vec%0d_pc", i),    bus.if_pc,       vecs[i].ep);
        check32($sformatf("vec%0d_plus4", i), bus.if_pc_plus4, vecs[i].ep + 32'd4);
        check32($sformatf("vec%0d_instr", i), bus.if_instr,    vecs[i].ep ^ PAT);
      end
      @(negedge clk);
    end

    // Random run against a queue model: the output register plus hold
    // buffer behave as a two-deep FIFO in front of decode.
    drive(1, 0, 0, 32'd0, 0, 32'd0);
    @(negedge clk);
    q.delete();
    mpc   = 32'd0;
    pend  = 32'd0;
    drain = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 99) < 30);
      d  = ($urandom_range(0, 99) < 10);
      t  = $urandom;
      er = !r && (q.size() < 2);
      a  = er && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      drive(r, s, d, t, a, rd);
      #1;
      check32("rnd_req",   {31'd0, bus.imem_req}, {31'd0, er});
      check32("rnd_addr",  bus.imem_addr,         mpc);
      check32("rnd_valid", {31'd0, bus.if_valid}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) begin
        check32("rnd_pc",    bus.if_pc,       q[0].pc);
        check32("rnd_plus4", bus.if_pc_plus4, q[0].pc + 32'd4);
        check32("rnd_instr", bus.if_instr,    q[0].instr);
      end

      if (r) begin
        q.delete();
        mpc   = 32'd0;
        drain = 1'b0;
      end else if (d) begin
        q.delete();
        if (er && !a) begin
          drain = 1'b1;
          pend  = t & ~32'd3;
        end else begin
          mpc   = t & ~32'd3;
          drain = 1'b0;
        end
      end else if (drain) begin
        if (a) begin
          mpc   = pend;
          drain = 1'b0;
        end
      end else begin
        if (!s && q.size() > 0) void'(q.pop_front());
        if (a) begin
          q.push_back('{pc: mpc, instr: rd});
          mpc = mpc + 32'd4;
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch stage for the MIPS datapath: owns the program counter, issues word fetches to instruction memory over a req/ack handshake, computes PC+4 and presents `{pc, pc+4, instr}` in an IF/ID output register to the decode stage. It absorbs decode back-pressure with a one-entry hold buffer and handles branch/jump redirects from EX, including flushing a fetch already in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset. Bits [1:0] must be 00.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode not ready; holds a valid output register.
- `redirect_valid`  in  1  single-cycle branch/jump taken pulse from EX.
- `redirect_target`  in  32  new PC; bits [1:0] ignored (treated as 00).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch word address; bits [1:0] always 00.
- `imem_ack`  in  1  memory response; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `if_valid`  out  1  output register holds a live instruction.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, modulo 2^32.
- `if_instr`  out  32  instruction word.

## Operation
- Registers: `pc`, `pend_pc` (redirect target saved while draining), state, output register, hold buffer `{hpc, hinstr}`.
- States: FETCH, HOLD, DRAIN. Reset -> FETCH, `pc = RESET_PC`, `if_valid = 0`, `if_pc = if_pc_plus4 = if_instr = 0`, hold buffer cleared.
- `imem_req = (state == FETCH || state == DRAIN) && !reset`; `imem_addr = pc`. Once raised, `imem_req` and `imem_addr` stay stable until `imem_ack` (except on reset).
- Output slot free = `!if_valid || !stall`. A transfer to decode occurs on any cycle with `if_valid && !stall`.
- FETCH, ack, slot free: output <= `{pc, pc+4, rdata}`, `if_valid = 1`, `pc <= pc+4`, stay FETCH.
- FETCH, ack, slot busy: hold <= `{pc, rdata}`, `pc <= pc+4`, go to HOLD.
- FETCH, no ack: stay FETCH; output register drains normally (`if_valid` clears on transfer).
- HOLD: `imem_req = 0`. On `!stall`: output <= `{hpc, hpc+4, hinstr}`, go to FETCH.
- Redirect has priority over everything except reset:
  - FETCH with ack in the same cycle: drop `rdata`, `pc <= target`, stay FETCH.
  - FETCH without ack: `pend_pc <= target`, go to DRAIN.
  - HOLD: drop hold buffer, `pc <= target`, go to FETCH.
  - DRAIN: `pend_pc <= target` (latest redirect wins). If ack arrives in the same cycle, `pc <= target`, go to FETCH.
  - All cases: `if_valid <= 0` next cycle, whatever `stall` is.
- DRAIN: request stays at the old `pc`. On ack, drop `rdata`, `pc <= pend_pc`, go to FETCH.
- Arithmetic: `pc + 4` wraps, so 32'hFFFF_FFFC -> 32'h0000_0000. Targets are masked with `& ~3`.
- Reset mid-fetch abandons the outstanding request. Instruction memory shares the same reset.

## Timing
- Zero-wait memory (ack in the request cycle) gives 1 instruction per cycle. Ack in cycle N -> `if_valid` and data visible in cycle N+1.
- Output register changes only when the slot is free or on a redirect flush. With `stall = 1` and `if_valid = 1`, all `if_*` outputs hold.
- Redirect in cycle N, not draining: `imem_addr = target` in N+1; first target instruction valid in N+2 at the earliest.
- Redirect while draining: the target request issues in the cycle after the drained ack.
- HOLD -> output load happens in the first `!stall` cycle. The next request issues in the following cycle.
- First request after reset deasserts: `imem_req = 1`, `imem_addr = RESET_PC`.

## Test plan
- Reset with zero-wait memory returning `instr = addr ^ 32'hA5A5_A5A5` -> outputs `if_pc` = 0, 4, 8, … on consecutive cycles; `if_pc_plus4 = if_pc + 4`; outputs are 0 and `if_valid = 0` during reset.
- Hold `stall` for 3 cycles with `if_pc = 8` valid -> outputs hold at 8; state enters HOLD with `hpc = 12` and `imem_req = 0`; after release, `if_pc` shows 12 then 16 with no loss and no duplicate.
- Memory with 2-cycle ack latency; `redirect_valid` with target 32'h0000_0103 while a fetch to 0x10 is pending -> `imem_addr` stays 0x10 until ack; 0x10 data never appears on the outputs; next request is 0x100; `if_valid` drops the cycle after the redirect.
- Redirect in the same cycle as ack and `stall = 1` -> data dropped, `if_valid = 0` next cycle, next `imem_addr` is the target.
- `RESET_PC = 32'hFFFF_FFF8` -> `if_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `if_pc_plus4` at FFFF_FFFC is 0.
- Assert `reset` during DRAIN and during HOLD -> next cycle: state FETCH, `imem_addr = RESET_PC`, `if_valid = 0`, hold buffer cleared.
